// File: rtl/cbus_arbiter_if.sv
// cbus_arbiter_if: cache-bus request/response types and the arbiter's master-side and memory-side bundle
package cbus_pkg;
    localparam logic [1:0] MLEN1 = 2'd0, MLEN2 = 2'd1, MLEN4 = 2'd2, MLEN8 = 2'd3;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [1:0]  len;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

interface cbus_arbiter_if #(parameter int N_PORTS = 2);
    import cbus_pkg::*;
    cbus_req_t  ireqs  [N_PORTS];
    cbus_resp_t iresps [N_PORTS];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    modport master (output ireqs, input iresps, input oreq, output oresp);
    modport slave  (input ireqs, output iresps, output oreq, input oresp);
endinterface

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter that grants one cache-bus master per burst onto the memory cbus
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int N_PORTS  = 2,
    parameter int IDX_BITS = $clog2(N_PORTS)
) (
    input logic           clk,
    input logic           resetn,
    cbus_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic [IDX_BITS-1:0] sel, sel_nxt, rr_ptr, rr_ptr_nxt, grant_idx;
    logic any_valid, burst_done, active;

    // Port reached by stepping off positions from the pointer; the wrap compares against N_PORTS so odd sizes work
    function automatic logic [IDX_BITS-1:0] port_at(input logic [IDX_BITS-1:0] ptr, input int off);
        int p;
        p = int'(ptr) + off;
        return IDX_BITS'(p >= N_PORTS ? p - N_PORTS : p);
    endfunction

    // Scan from the far end back toward rr_ptr so the closest valid port is the one left standing
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (bus.ireqs[port_at(rr_ptr, i)].valid) begin
                grant_idx = port_at(rr_ptr, i);
                any_valid = 1'b1;
            end
        end
    end

    // Grant on the first IDLE cycle with a request; only the final response beat releases it
    always_comb begin
        burst_done = state == BUSY && bus.oresp.ready && bus.oresp.last;
        state_nxt  = (state == IDLE && any_valid) ? BUSY : burst_done ? IDLE : state;
        sel_nxt    = (state == IDLE && any_valid) ? grant_idx : sel;
        rr_ptr_nxt = !burst_done ? rr_ptr : (sel == IDX_BITS'(N_PORTS - 1)) ? '0 : sel + IDX_BITS'(1);
    end

    // Pure pass-through while granted; resetn gates it so outputs clear without waiting for a clock
    always_comb begin
        active   = state == BUSY && resetn;
        bus.oreq = active ? bus.ireqs[sel] : '0;
        for (int i = 0; i < N_PORTS; i++)
            bus.iresps[i] = (active && sel == IDX_BITS'(i)) ? bus.oresp : '0;
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end
endmodule
